// File: rtl/instr_sequencer.sv
// ============================================================================
// Module  : instr_sequencer
// Brief   : Fetches words from a synchronous program ROM and feeds a 9-bit
//           processor through its DIN/Run handshake, with halt and timeout.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_sequencer #(
    parameter int ADDR_W     = 6,
    parameter int START_ADDR = 0,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [8:0]        i_mem_data,
    input  logic              i_done,
    output logic [8:0]        o_din,
    output logic              o_run,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_timed_out
);

    localparam int                c_TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TW-1:0]   c_TLAST    = c_TW'(TIMEOUT - 1);
    localparam logic [2:0]        c_OP_MVI   = 3'b001;
    localparam logic [2:0]        c_OP_HALT  = 3'b111;
    localparam logic [ADDR_W-1:0] c_START    = ADDR_W'(START_ADDR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_FIMM  = 3'd3,
        S_ISSUE = 3'd4,
        S_EXEC  = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [8:0]        r_din;
    logic              r_run;
    logic              r_halted;
    logic              r_timed_out;
    logic [8:0]        r_instr;
    logic [8:0]        r_imm;
    logic [c_TW-1:0]   r_timer;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_instr_mvi;

    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_instr_mvi = (r_instr[8:6] == c_OP_MVI);
    assign w_pc_next   = w_instr_mvi ? (r_pc + ADDR_W'(2)) : w_pc_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= c_START;
            r_mem_addr  <= c_START;
            r_din       <= '0;
            r_run       <= 1'b0;
            r_halted    <= 1'b0;
            r_timed_out <= 1'b0;
            r_instr     <= '0;
            r_imm       <= '0;
            r_timer     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_run <= 1'b0;
                    r_din <= '0;
                    if (i_start) begin
                        r_halted    <= 1'b0;
                        r_timed_out <= 1'b0;
                        r_state     <= S_FETCH;
                    end
                end
                // Address PC+1 is presented speculatively during LATCH so the
                // immediate word is already on MemData when S_FIMM samples it.
                S_FETCH: begin
                    r_mem_addr <= w_pc_inc;
                    r_state    <= S_LATCH;
                end
                S_LATCH: begin
                    r_instr <= i_mem_data;
                    if (i_mem_data[8:6] == c_OP_HALT) begin
                        r_mem_addr <= r_pc;
                        r_halted   <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (i_mem_data[8:6] == c_OP_MVI) begin
                        r_state <= S_FIMM;
                    end else begin
                        r_mem_addr <= r_pc;
                        r_din      <= i_mem_data;
                        r_run      <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_FIMM: begin
                    r_imm      <= i_mem_data;
                    r_mem_addr <= r_pc;
                    r_din      <= r_instr;
                    r_run      <= 1'b1;
                    r_timer    <= '0;
                    r_state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_run   <= 1'b0;
                    r_din   <= w_instr_mvi ? r_imm : r_instr;
                    r_timer <= '0;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (i_done) begin
                        r_pc       <= w_pc_next;
                        r_mem_addr <= w_pc_next;
                        r_din      <= '0;
                        r_state    <= S_FETCH;
                    end else if (r_timer == c_TLAST) begin
                        r_timed_out <= 1'b1;
                        r_din       <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + c_TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_din       = r_din;
    assign o_run       = r_run;
    assign o_pc        = r_pc;
    assign o_busy      = (r_state != S_IDLE);
    assign o_halted    = r_halted;
    assign o_timed_out = r_timed_out;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module  : tb_instr_sequencer
// Brief   : Directed bench for instr_sequencer (6-bit PC instance plus a
//           2-bit PC instance for address wrap).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, done = 1'b0;
    logic       start2 = 1'b0, done2 = 1'b0;
    logic [5:0] mem_addr, pc;
    logic [1:0] mem_addr2, pc2;
    logic [8:0] mem_data, mem_data2, din, din2;
    logic       run, busy, halted, timed_out;
    logic       run2, busy2, halted2, timed_out2;
    logic [8:0] rom  [0:63];
    logic [8:0] rom2 [0:3];

    int vectors = 0;
    int errors  = 0;
    int run_cnt = 0;
    int run_long = 0;
    logic run_prev = 1'b0;
    int base;

    always #5 clk = ~clk;

    always @(posedge clk) mem_data  <= rom[mem_addr];
    always @(posedge clk) mem_data2 <= rom2[mem_addr2];

    always @(negedge clk) begin
        if (run) run_cnt++;
        if (run && run_prev) run_long++;
        run_prev = run;
    end

    instr_sequencer #(.ADDR_W(6), .START_ADDR(0), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .i_start(start), .o_mem_addr(mem_addr),
        .i_mem_data(mem_data), .i_done(done), .o_din(din), .o_run(run),
        .o_pc(pc), .o_busy(busy), .o_halted(halted), .o_timed_out(timed_out)
    );

    instr_sequencer #(.ADDR_W(2), .START_ADDR(3), .TIMEOUT(4)) dut2 (
        .clk(clk), .rst(rst), .i_start(start2), .o_mem_addr(mem_addr2),
        .i_mem_data(mem_data2), .i_done(done2), .o_din(din2), .o_run(run2),
        .o_pc(pc2), .o_busy(busy2), .o_halted(halted2), .o_timed_out(timed_out2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        vectors++; if (pc !== 6'd0)       begin errors++; $display("FAIL rst_pc: got %0d want 0", pc); end
        vectors++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
        vectors++; if (din !== 9'd0)      begin errors++; $display("FAIL rst_din: got %o want 0", din); end
        vectors++; if (run !== 1'b0)      begin errors++; $display("FAIL rst_run: got %b want 0", run); end
        vectors++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (halted !== 1'b0 || timed_out !== 1'b0)
            begin errors++; $display("FAIL rst_flags: got %b%b want 00", halted, timed_out); end
        vectors++; if (pc2 !== 2'd3)      begin errors++; $display("FAIL rst_pc2: got %0d want 3", pc2); end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_mv();
        rom[0] = 9'o010; rom[1] = 9'o700;
        start = 1'b1; step(1); start = 1'b0;
        vectors++; if (busy !== 1'b1 || mem_addr !== 6'd0)
            begin errors++; $display("FAIL mv_fetch: got busy=%b addr=%0d want 1,0", busy, mem_addr); end
        step(2);
        vectors++; if (run !== 1'b1 || din !== 9'o010)
            begin errors++; $display("FAIL mv_issue: got run=%b din=%o want 1,010", run, din); end
        step(1);
        vectors++; if (run !== 1'b0 || din !== 9'o010)
            begin errors++; $display("FAIL mv_exec: got run=%b din=%o want 0,010", run, din); end
        done = 1'b1; step(1); done = 1'b0;
        vectors++; if (pc !== 6'd1 || mem_addr !== 6'd1)
            begin errors++; $display("FAIL mv_pc: got pc=%0d addr=%0d want 1,1", pc, mem_addr); end
        step(2);
        vectors++; if (halted !== 1'b1 || busy !== 1'b0 || pc !== 6'd1)
            begin errors++; $display("FAIL mv_halt: got h=%b b=%b pc=%0d want 1,0,1", halted, busy, pc); end
    endtask

    task automatic test_mvi_halt();
        reset_pulse();
        rom[0] = 9'o120; rom[1] = 9'h0A5; rom[2] = 9'o700;
        base = run_cnt;
        start = 1'b1; step(1); start = 1'b0;
        step(1);
        vectors++; if (mem_addr !== 6'd1)
            begin errors++; $display("FAIL mvi_immaddr: got %0d want 1", mem_addr); end
        step(2);
        vectors++; if (run !== 1'b1 || din !== 9'o120)
            begin errors++; $display("FAIL mvi_issue: got run=%b din=%o want 1,120", run, din); end
        step(1);
        vectors++; if (run !== 1'b0 || din !== 9'h0A5)
            begin errors++; $display("FAIL mvi_exec: got run=%b din=%h want 0,0a5", run, din); end
        done = 1'b1; step(1); done = 1'b0;
        vectors++; if (pc !== 6'd2)
            begin errors++; $display("FAIL mvi_pc: got %0d want 2", pc); end
        step(2);
        vectors++; if (halted !== 1'b1 || busy !== 1'b0 || pc !== 6'd2)
            begin errors++; $display("FAIL halt_state: got h=%b b=%b pc=%0d want 1,0,2", halted, busy, pc); end
        vectors++; if (run_cnt - base !== 1)
            begin errors++; $display("FAIL halt_runs: got %0d want 1", run_cnt - base); end
        start = 1'b1; step(1); start = 1'b0;
        vectors++; if (halted !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL resume_clear: got h=%b b=%b want 0,1", halted, busy); end
        step(2);
        vectors++; if (halted !== 1'b1 || pc !== 6'd2 || run_cnt - base !== 1)
            begin errors++; $display("FAIL resume_rehalt: got h=%b pc=%0d runs=%0d want 1,2,1", halted, pc, run_cnt - base); end
    endtask

    task automatic test_timeout();
        reset_pulse();
        rom[0] = 9'o200; rom[1] = 9'o700;
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        step(14);
        vectors++; if (busy !== 1'b1 || timed_out !== 1'b0)
            begin errors++; $display("FAIL to_early: got b=%b to=%b want 1,0", busy, timed_out); end
        step(1);
        vectors++; if (timed_out !== 1'b1 || busy !== 1'b0 || pc !== 6'd0 || din !== 9'd0)
            begin errors++; $display("FAIL to_abort: got to=%b b=%b pc=%0d din=%o want 1,0,0,0", timed_out, busy, pc, din); end
        start = 1'b1; step(1); start = 1'b0;
        vectors++; if (timed_out !== 1'b0)
            begin errors++; $display("FAIL to_clear: got %b want 0", timed_out); end
        step(3);
        step(14);
        done = 1'b1; step(1); done = 1'b0;
        vectors++; if (timed_out !== 1'b0 || pc !== 6'd1 || busy !== 1'b1)
            begin errors++; $display("FAIL to_donewins: got to=%b pc=%0d b=%b want 0,1,1", timed_out, pc, busy); end
    endtask

    task automatic test_reset_mid_exec();
        reset_pulse();
        rom[0] = 9'o010; rom[1] = 9'o010;
        start = 1'b1; step(1); start = 1'b0;
        step(3);
        done = 1'b1; step(1); done = 1'b0;
        step(3);
        vectors++; if (busy !== 1'b1 || pc !== 6'd1 || din !== 9'o010)
            begin errors++; $display("FAIL rx_pre: got b=%b pc=%0d din=%o want 1,1,010", busy, pc, din); end
        rst = 1'b1; step(1); rst = 1'b0;
        vectors++; if (pc !== 6'd0 || run !== 1'b0 || din !== 9'd0 || busy !== 1'b0)
            begin errors++; $display("FAIL rx_reset: got pc=%0d run=%b din=%o b=%b want 0,0,0,0", pc, run, din, busy); end
        done = 1'b1; step(2); done = 1'b0;
        vectors++; if (busy !== 1'b0 || pc !== 6'd0)
            begin errors++; $display("FAIL rx_doneign: got b=%b pc=%0d want 0,0", busy, pc); end
    endtask

    task automatic test_wrap();
        reset_pulse();
        rom2[3] = 9'o130; rom2[0] = 9'h055; rom2[1] = 9'o700; rom2[2] = 9'o700;
        start2 = 1'b1; step(1); start2 = 1'b0;
        vectors++; if (mem_addr2 !== 2'd3)
            begin errors++; $display("FAIL wrap_addr3: got %0d want 3", mem_addr2); end
        step(1);
        vectors++; if (mem_addr2 !== 2'd0)
            begin errors++; $display("FAIL wrap_addr0: got %0d want 0", mem_addr2); end
        step(2);
        vectors++; if (run2 !== 1'b1 || din2 !== 9'o130)
            begin errors++; $display("FAIL wrap_issue: got run=%b din=%o want 1,130", run2, din2); end
        step(1);
        vectors++; if (din2 !== 9'h055)
            begin errors++; $display("FAIL wrap_imm: got %h want 055", din2); end
        done2 = 1'b1; step(1); done2 = 1'b0;
        vectors++; if (pc2 !== 2'd1)
            begin errors++; $display("FAIL wrap_pc: got %0d want 1", pc2); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 9'o700;
        for (int i = 0; i < 4; i++) rom2[i] = 9'o700;
        test_reset();
        test_mv();
        test_mvi_halt();
        test_timeout();
        test_reset_mid_exec();
        test_wrap();
        vectors++; if (run_long !== 0)
            begin errors++; $display("FAIL run_width: got %0d long pulses want 0", run_long); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
